// File: rtl/ntru_pkg.sv
// ntru_pkg: shared constants, state encoding and ternary-to-mod-q mapping for the coefficient streamer
package ntru_pkg;
  localparam int N = 701;
  localparam int QW = 13;
  localparam int LANES = 16;
  localparam int BEATS = (N + LANES - 1) / LANES;
  localparam logic [1:0] TRI_ZERO = 2'b00;
  localparam logic [1:0] TRI_POS = 2'b01;
  localparam logic [1:0] TRI_NEG = 2'b11;
  localparam logic [1:0] TRI_BAD = 2'b10;
  typedef enum logic [2:0] {S_LOAD, S_EN, S_STREAM, S_TAIL, S_DONE} state_t;
  function automatic logic [QW-1:0] tri_to_modq(input logic [1:0] c);
    return c == TRI_POS ? QW'(1) : c == TRI_NEG ? {QW{1'b1}} : '0;
  endfunction
endpackage

// File: rtl/tri_lane_decode.sv
// tri_lane_decode: sanitises one 2-bit ternary lane, flagging the illegal code and storing it as zero
module tri_lane_decode
  import ntru_pkg::*;
(
  input  logic [1:0] i_code,
  output logic [1:0] o_code,
  output logic       o_bad
);
  assign o_bad = i_code == TRI_BAD;
  assign o_code = o_bad ? TRI_ZERO : i_code;
endmodule

// File: rtl/ternary_coeff_streamer.sv
// ternary_coeff_streamer: buffers a packed ternary polynomial, then streams it high-index-first to the multiplier
module ternary_coeff_streamer
  import ntru_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*LANES-1:0]   in_data,
  input  logic                 in_last,
  output logic                 mul_en,
  output logic [QW-1:0]        mul_c,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int IW = $clog2(N);
  localparam int BW = $clog2(BEATS);
  state_t r_state, w_next;
  logic [BW-1:0] r_beat;
  logic [IW-1:0] r_idx, w_idx_n, w_rd, r_lim, w_lim_early;
  logic [1:0] r_buf [N];
  logic [1:0] w_code [LANES];
  logic [LANES-1:0] w_bad, w_bad_v;
  logic w_acc, w_last_beat, w_fin, w_early;
  logic r_mul_en, r_done, r_err;
  logic [QW-1:0] r_mul_c;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    tri_lane_decode u_dec (.i_code(in_data[2*k+:2]), .o_code(w_code[k]), .o_bad(w_bad[k]));
    assign w_bad_v[k] = w_bad[k] & (r_beat != BW'(BEATS-1) || k < N - (BEATS-1)*LANES);
  end
  assign in_ready = r_state == S_LOAD;
  assign busy = !in_ready;
  assign w_acc = in_valid & in_ready;
  assign w_last_beat = r_beat == BW'(BEATS-1);
  assign w_fin = w_acc & (w_last_beat | in_last);
  assign w_early = w_acc & in_last & !w_last_beat;
  assign w_lim_early = IW'(r_beat + 1'b1) << $clog2(LANES);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD:   w_next = w_fin ? S_EN : S_LOAD;
      S_EN:     w_next = S_STREAM;
      S_STREAM: w_next = r_idx == IW'(N-1) ? S_TAIL : S_STREAM;
      S_TAIL:   w_next = S_DONE;
      default:  w_next = S_LOAD;
    endcase
    w_idx_n = (r_state == S_STREAM && w_next == S_STREAM) ? r_idx + 1'b1 : '0;
    w_rd = IW'(N-1) - w_idx_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_beat <= '0;
      r_idx <= '0;
      r_mul_en <= 1'b0;
      r_mul_c <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_beat <= w_next != S_LOAD ? '0 : r_beat + BW'(w_acc);
      r_idx <= w_idx_n;
      r_mul_en <= w_next == S_EN;
      r_mul_c <= w_next == S_STREAM ? tri_to_modq(w_rd < r_lim ? r_buf[w_rd] : TRI_ZERO) : '0;
      r_done <= w_next == S_DONE;
      r_err <= r_err | w_early | (w_acc & |w_bad_v);
    end
  end
  // coefficients at or above r_lim were never loaded and read back as zero
  always_ff @(posedge clk) begin
    if (w_fin) r_lim <= w_early ? w_lim_early : IW'(N);
    for (int i = 0; i < N; i++)
      if (w_acc && r_beat == BW'(i / LANES)) r_buf[i] <= w_code[i % LANES];
  end
  assign mul_en = r_mul_en;
  assign mul_c = r_mul_c;
  assign done = r_done;
  assign err = r_err;
endmodule

// File: tb/tb_ternary_coeff_streamer.sv
// tb_ternary_coeff_streamer: vector table plus corner sequences against a coefficient-array reference model
module tb_ternary_coeff_streamer;
  import ntru_pkg::*;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, mul_en, busy, done, err;
  logic [2*LANES-1:0] in_data;
  logic [QW-1:0] mul_c;
  int n_cmp = 0;
  int n_bad = 0;
  int val [N];
  int codes [BEATS*LANES];
  typedef struct {
    string name;
    int    mode;
    int    last_beat;
    int    bad_pos;
    bit    ghost;
    bit    exp_err;
  } vec_t;
  vec_t vt [7];
  ternary_coeff_streamer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .mul_en(mul_en), .mul_c(mul_c), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic int expc(input int j);
    int v = val[N-1-j];
    return v < 0 ? (1 << QW) - 1 : v;
  endfunction
  task automatic build(input int mode, input int last_beat, input int bad_pos, input bit ghost);
    for (int i = 0; i < BEATS*LANES; i++) begin
      int v;
      v = (mode == 2) ? int'($urandom_range(2)) - 1 : 0;
      if (mode == 1) v = (i == N-1) ? 1 : (i == 0) ? -1 : 0;
      codes[i] = v == 1 ? 1 : v == -1 ? 3 : 0;
      if (i < N) val[i] = (i < (last_beat + 1) * LANES) ? v : 0;
    end
    if (bad_pos >= 0) begin
      codes[bad_pos] = 2;
      val[bad_pos] = 0;
    end
    if (ghost) for (int i = N; i < BEATS*LANES; i++) codes[i] = 1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic run_poly(input string tag, input int last_beat, input bit exp_err, input int abort_cyc);
    int ens, dn_at, dn_extra, mism;
    logic [2*LANES-1:0] d;
    ens = 0; dn_at = -1; dn_extra = 0; mism = 0;
    for (int b = 0; b <= last_beat; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if ($urandom_range(1) == 1) @(negedge clk);
      for (int k = 0; k < LANES; k++) d[2*k+:2] = 2'(codes[b*LANES+k]);
      in_data = d;
      in_last = (b == last_beat);
      in_valid = 1'b1;
      @(posedge clk);
    end
    for (int c = 1; c <= 705; c++) begin
      @(negedge clk);
      in_valid = (abort_cyc == 0 && c < 704) ? 1'($urandom_range(1)) : 1'b0;
      in_data = $urandom;
      in_last = 1'($urandom_range(1));
      if (abort_cyc > 0 && c == abort_cyc + 1) begin
        chk({tag, " mul_c after rst"}, int'(mul_c), 0);
        chk({tag, " mul_en after rst"}, int'(mul_en), 0);
        chk({tag, " in_ready after rst"}, int'(in_ready), 1);
        chk({tag, " busy after rst"}, int'(busy), 0);
        rst = 1'b0;
        repeat (710) begin
          @(negedge clk);
          dn_extra += int'(done) + int'(mul_en);
        end
        chk({tag, " done/en after rst"}, dn_extra, 0);
        return;
      end
      if (c == 1) begin
        chk({tag, " en pulse"}, int'(mul_en), 1);
        chk({tag, " en mul_c"}, int'(mul_c), 0);
        chk({tag, " en in_ready"}, int'(in_ready), 0);
        chk({tag, " en busy"}, int'(busy), 1);
      end else ens += int'(mul_en);
      if (c >= 2 && c <= 702 && int'(mul_c) != expc(c - 2)) begin
        if (mism == 0) $display("  %s first stream diff at idx %0d: got %0d want %0d", tag, c - 2, mul_c, expc(c - 2));
        mism++;
      end
      if (c == 703) chk({tag, " tail mul_c"}, int'(mul_c), 0);
      if (done) begin
        if (dn_at < 0) dn_at = c;
        else dn_extra++;
      end
      if (c == 705) begin
        chk({tag, " ready after done"}, int'(in_ready), 1);
        chk({tag, " busy after done"}, int'(busy), 0);
      end
      if (c == abort_cyc) rst = 1'b1;
    end
    chk({tag, " extra en"}, ens, 0);
    chk({tag, " stream diffs"}, mism, 0);
    chk({tag, " done cycle"}, dn_at, 704);
    chk({tag, " extra done"}, dn_extra, 0);
    chk({tag, " err"}, int'(err), int'(exp_err));
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    vt[0] = '{"zero",    0, 43, -1, 1'b0, 1'b0};
    vt[1] = '{"edges",   1, 43, -1, 1'b0, 1'b0};
    vt[2] = '{"ghost",   0, 43, -1, 1'b1, 1'b0};
    vt[3] = '{"bad37",   2, 43, 37, 1'b0, 1'b1};
    vt[4] = '{"early10", 2, 10, -1, 1'b0, 1'b1};
    vt[5] = '{"rand_a",  2, 43, -1, 1'b0, 1'b0};
    vt[6] = '{"rand_b",  2, 43, -1, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset mul_en", int'(mul_en), 0);
    chk("reset mul_c", int'(mul_c), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    rst = 1'b0;
    foreach (vt[i]) begin
      do_reset();
      build(vt[i].mode, vt[i].last_beat, vt[i].bad_pos, vt[i].ghost);
      run_poly(vt[i].name, vt[i].last_beat, vt[i].exp_err, 0);
    end
    do_reset();
    build(2, 43, 37, 1'b0);
    run_poly("sticky_a", 43, 1'b1, 0);
    build(2, 43, -1, 1'b0);
    run_poly("sticky_b2b", 43, 1'b1, 0);
    do_reset();
    build(2, 43, -1, 1'b0);
    run_poly("abort300", 43, 1'b0, 302);
    build(2, 43, -1, 1'b0);
    run_poly("after_abort", 43, 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
